mult_fu_pipe: RTL
=================

Name: mult_fu_pipe

Overview:
- Pipelined integer multiply functional unit directly downstream of the reservation station.
- Accepts one issued RV32M multiply per cycle: operands already read from the physical register file, plus destination tag.
- Computes the product over STAGES pipeline stages and requests the CDB to broadcast the result and dest tag back to the RS, map table and ROB.
- Applies backpressure to RS issue when a finished result cannot get a CDB grant.

Parameters:
XLEN, 32, operand/result width
STAGES, 4, pipeline depth; must divide 2*XLEN (valid: 1, 2, 4, 8)
PREG_NUMBER, 64, physical registers; tag width TW = $clog2(PREG_NUMBER)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
valid_i  in  1  RS issues a multiply this cycle
func_i  in  2  MUL_FUNC: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
rs1_val_i  in  XLEN  multiplicand operand
rs2_val_i  in  XLEN  multiplier operand
dest_tag_i  in  TW  destination physical register
branch_recover_i  in  1  squash all in-flight ops
cdb_grant_i  in  1  CDB arbiter accepts the current request
fu_ready_o  out  1  unit can accept valid_i this cycle (to RS fu_ready bit)
cdb_req_o  out  1  result valid, requesting CDB
cdb_tag_o  out  TW  dest tag of result
cdb_value_o  out  XLEN  result value

Behaviour:
- Reset (async, immediate): all stage valid bits 0; cdb_req_o=0, cdb_tag_o=0, cdb_value_o=0. fu_ready_o=1 while in reset and after release.
- advance = !cdb_req_o || cdb_grant_i. fu_ready_o = advance (combinational; no bubble collapsing). When advance=0, every stage holds, including the data of invalid stages.
- Accept: on a clk edge with valid_i && fu_ready_o && !branch_recover_i, stage 0 loads the operation. valid_i while fu_ready_o=0 is an RS protocol error and is ignored.
- Latency: accepted at edge N with no stall gives cdb_req_o=1 after edge N+STAGES. Each stall cycle adds one. Throughput is 1 op/cycle when granted every cycle.
- cdb_req_o/tag/value are registered; they stay stable while cdb_req_o && !cdb_grant_i. On grant, the next valid op (or nothing) moves in at the same edge.
- Operand extension at stage 0, to 2*XLEN bits:
  - MUL and MULH: both operands sign-extended.
  - MULHSU: rs1 sign-extended, rs2 zero-extended.
  - MULHU: both operands zero-extended.
- Stage k adds (mcand << k*C) * mplier[k*C +: C] into a 2*XLEN accumulator, where C = 2*XLEN/STAGES. Arithmetic is modulo 2^(2*XLEN).
- Final result:
  - MUL: product[XLEN-1:0].
  - Others: product[2*XLEN-1:XLEN].
- Each stage carries: valid, func, tag, mcand, mplier, accumulator.
- branch_recover_i: at the next edge all stage valid bits and cdb_req_o clear. Squash beats a same-cycle accept and a same-cycle grant; the CDB arbiter masks the squashed broadcast itself.
- Reset mid-operation: all in-flight ops are discarded, with no partial output.

Decomposition:
- Shared package (ISA.svh):
  - MUL_FUNC enum.
  - MULT_STAGE_PACKET struct: valid, func, dest_tag, mcand, mplier, acc.
  - XLEN/STAGES/PREG_NUMBER defines, alongside PREG_NUMBER/FU_NUMBER.
- One sub-module: mult_stage. Combinational partial-product step, instantiated STAGES times in a generate loop. Pipeline registers live in mult_fu_pipe.

Test Plan:
- Reset then MUL 7*6, tag 5, grant held 1 -> cdb_req_o=1 exactly 4 cycles later, tag 5, value 42; fu_ready_o=1 throughout.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF. MULHU same operands -> 0xFFFFFFFE. MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE.
- Back-to-back 4 ops (tags 1-4), grant=1 -> four consecutive cdb_req_o cycles, tags 1,2,3,4 in order.
- Stall: result ready, grant=0 for 3 cycles -> cdb outputs stable, fu_ready_o=0 for those 3 cycles; grant=1 -> next op appears the following cycle, no op lost or duplicated.
- 3 ops in flight, branch_recover_i=1 together with valid_i=1 -> no cdb_req_o for the next 6 cycles; a new op accepted after recover completes normally in 4 cycles.
- Assert reset asynchronously mid-flight (between edges) -> cdb_req_o drops to 0 immediately, and no stale result appears after release.

Source files
------------

// File: rtl/mult_fu_pipe_pkg.sv
// Shared types and sizing for the pipelined RV32M multiply functional unit.
package mult_fu_pipe_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned STAGES      = 4;
   localparam int unsigned PREG_NUMBER = 64;
   localparam int unsigned FU_NUMBER   = 4;
   localparam int unsigned TW          = $clog2(PREG_NUMBER);

   // Double-width datapath and the multiplier chunk consumed per stage
   localparam int unsigned DW    = 2 * XLEN;
   localparam int unsigned CHUNK = DW / STAGES;

   typedef enum logic [1:0] {
      MUL    = 2'd0,
      MULH   = 2'd1,
      MULHSU = 2'd2,
      MULHU  = 2'd3
   } MUL_FUNC;

   typedef struct packed {
      logic            valid;
      MUL_FUNC         func;
      logic [TW-1:0]   dest_tag;
      logic [DW-1:0]   mcand;
      logic [DW-1:0]   mplier;
      logic [DW-1:0]   acc;
   } MULT_STAGE_PACKET;

   // Widen an operand to the double-width datapath, signed or unsigned
   function automatic logic [DW-1:0] extend_operand(input logic [XLEN-1:0] value,
                                                     input logic          is_signed);
      logic [DW-1:0] wide;
      wide = '0;
      wide[XLEN-1:0] = value;
      if (is_signed && value[XLEN-1]) begin
         wide[DW-1:XLEN] = '1;
      end
      return wide;
   endfunction

endpackage

// File: rtl/mult_stage.sv
// One combinational partial-product step: adds the K-th shifted chunk product.
module mult_stage
   import mult_fu_pipe_pkg::*;
#(
   parameter int unsigned K = 0
) (
   input  MULT_STAGE_PACKET stage_in,
   output MULT_STAGE_PACKET stage_out
);

   localparam int unsigned SHIFT = K * CHUNK;

   logic [DW-1:0] digit;
   logic [DW-1:0] partial;

   // Accumulate (mcand << K*C) * mplier[K*C +: C] modulo 2^DW; other fields pass through
   always_comb begin
      digit              = '0;
      digit[CHUNK-1:0]   = stage_in.mplier[SHIFT +: CHUNK];
      partial            = (stage_in.mcand << SHIFT) * digit;
      stage_out          = stage_in;
      stage_out.acc      = stage_in.acc + partial;
   end

endmodule

// File: rtl/mult_fu_pipe.sv
// Pipelined integer multiply unit between the reservation station and the CDB.
module mult_fu_pipe
   import mult_fu_pipe_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            valid_i,
   input  logic [1:0]      func_i,
   input  logic [XLEN-1:0] rs1_val_i,
   input  logic [XLEN-1:0] rs2_val_i,
   input  logic [TW-1:0]   dest_tag_i,
   input  logic            branch_recover_i,
   input  logic            cdb_grant_i,
   output logic            fu_ready_o,
   output logic            cdb_req_o,
   output logic [TW-1:0]   cdb_tag_o,
   output logic [XLEN-1:0] cdb_value_o
);

   MULT_STAGE_PACKET stage_q    [STAGES];
   MULT_STAGE_PACKET stage_step [STAGES];
   MULT_STAGE_PACKET load_pkt;
   MULT_STAGE_PACKET last_pkt;
   logic [XLEN-1:0]  result_value;
   logic             advance;

   // The whole pipe moves together; a held CDB request freezes every stage
   assign advance    = !cdb_req_o || cdb_grant_i;
   assign fu_ready_o = advance;

   // Build the stage-0 packet with operands extended according to the function
   always_comb begin
      load_pkt          = '0;
      load_pkt.valid    = valid_i;
      load_pkt.func     = MUL_FUNC'(func_i);
      load_pkt.dest_tag = dest_tag_i;
      load_pkt.mcand    = extend_operand(rs1_val_i, func_i != MULHU);
      load_pkt.mplier   = extend_operand(rs2_val_i, (func_i == MUL) || (func_i == MULH));
      load_pkt.acc      = '0;
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      mult_stage #(.K(k)) u_mult_stage (
         .stage_in  (stage_q[k]),
         .stage_out (stage_step[k])
      );
   end

   // Select low or high half of the finished product for the broadcast
   always_comb begin
      last_pkt     = stage_step[STAGES-1];
      result_value = (last_pkt.func == MUL) ? last_pkt.acc[XLEN-1:0]
                                            : last_pkt.acc[DW-1:XLEN];
   end

   // Pipeline and CDB output registers; squash has priority over accept and grant
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < STAGES; i++) begin
            stage_q[i] <= '0;
         end
         cdb_req_o   <= 1'b0;
         cdb_tag_o   <= '0;
         cdb_value_o <= '0;
      end else if (branch_recover_i) begin
         for (int unsigned i = 0; i < STAGES; i++) begin
            stage_q[i].valid <= 1'b0;
         end
         cdb_req_o <= 1'b0;
      end else if (advance) begin
         stage_q[0] <= load_pkt;
         for (int unsigned i = 1; i < STAGES; i++) begin
            stage_q[i] <= stage_step[i-1];
         end
         cdb_req_o   <= last_pkt.valid;
         cdb_tag_o   <= last_pkt.dest_tag;
         cdb_value_o <= result_value;
      end
   end

endmodule
